// File: rtl/harvard_pkg.sv
// Shared types and decode helpers for the Harvard sequencer.
// Instruction word: [15:11] opcode, [10:8] ALU output selector, [7:0] data address.
package harvard_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT,
    PAUSE
  } seqStateT;

  localparam int INSTR_WIDTH = 16;
  localparam int OPC_MSB     = 15;
  localparam int OPC_LSB     = 11;
  localparam int SEL_MSB     = 10;
  localparam int SEL_LSB     = 8;
  localparam int ADDR_MSB    = 7;
  localparam int ADDR_LSB    = 0;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b00001;
  localparam logic [4:0] OP_STORE = 5'b00010;
  localparam logic [4:0] OP_JMP   = 5'b01000;
  localparam logic [4:0] OP_JMPC  = 5'b01001;
  // Any opcode with bit 4 set is arithmetic; the ALU interprets the rest.
  localparam int OP_ARITH_BIT = 4;

  // Jump class: the ALU has already resolved any condition into its PC output.
  function automatic logic isJump(input logic [4:0] op);
    return op[4:3] == 2'b01;
  endfunction

  function automatic logic isStore(input logic [4:0] op);
    return op == OP_STORE;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer-to-ALU/memory bus. The master side is the sequencer; the slave side
// is the ALU, program ROM and data memory taken together.
interface control_sequencer_if #(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16
);
  import harvard_pkg::*;

  logic [PC_WIDTH-1:0]    ProgramAddressOutput;
  logic [INSTR_WIDTH-1:0] ProgramDataInput;
  logic [4:0]             OperandOutput;
  logic [2:0]             OutputSelectorOutput;
  logic [DATA_WIDTH-1:0]  AccumulatorOutput;
  logic [DATA_WIDTH-1:0]  AccumulatorWriteInput;
  logic                   ConditionFlagOutput;
  logic                   ConditionFlagWriteInput;
  logic [PC_WIDTH-1:0]    ProgramCounterInput;
  logic                   EndFlagInput;
  logic [7:0]             DataAddressOutput;
  logic                   DataWriteEnableOutput;

  modport master (
    output ProgramAddressOutput, OperandOutput, OutputSelectorOutput,
           AccumulatorOutput, ConditionFlagOutput, DataAddressOutput,
           DataWriteEnableOutput,
    input  ProgramDataInput, AccumulatorWriteInput, ConditionFlagWriteInput,
           ProgramCounterInput, EndFlagInput
  );

  modport slave (
    input  ProgramAddressOutput, OperandOutput, OutputSelectorOutput,
           AccumulatorOutput, ConditionFlagOutput, DataAddressOutput,
           DataWriteEnableOutput,
    output ProgramDataInput, AccumulatorWriteInput, ConditionFlagWriteInput,
           ProgramCounterInput, EndFlagInput
  );

endinterface

// File: rtl/sequencer_fsm.sv
// Four-phase instruction state machine with registered busy/halted flags.
// SINGLE_STEP_EN adds stepInput and parks in PAUSE after every WRITEBACK.
module sequencer_fsm
  import harvard_pkg::*;
(
  input  logic     clkInput,
  input  logic     resetNInput,
  input  logic     startInput,
`ifdef SINGLE_STEP_EN
  input  logic     stepInput,
`endif
  input  logic     endFlagInput,
  output seqStateT state,
  output logic     busyOutput,
  output logic     haltedOutput
);

  always_ff @(posedge clkInput) begin
    if (!resetNInput) begin
      state        <= IDLE;
      busyOutput   <= 1'b0;
      haltedOutput <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: if (startInput) begin
          state        <= FETCH;
          busyOutput   <= 1'b1;
          haltedOutput <= 1'b0;
        end
        FETCH:   state <= DECODE;
        DECODE:  state <= EXECUTE;
        EXECUTE: state <= WRITEBACK;
        // End flag is only meaningful here; the ALU raises it alongside its results.
        WRITEBACK: if (endFlagInput) begin
          state        <= HALT;
          busyOutput   <= 1'b0;
          haltedOutput <= 1'b1;
        end else begin
`ifdef SINGLE_STEP_EN
          state      <= PAUSE;
          busyOutput <= 1'b0;
`else
          state      <= FETCH;
`endif
        end
`ifdef SINGLE_STEP_EN
        PAUSE: if (stepInput) begin
          state      <= FETCH;
          busyOutput <= 1'b1;
        end
`endif
        default: begin
          state        <= IDLE;
          busyOutput   <= 1'b0;
          haltedOutput <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Harvard instruction sequencer: owns PC, IR, accumulator and condition flag,
// feeds the ALU from IR and commits ALU results in WRITEBACK. Option: SINGLE_STEP_EN.
module control_sequencer
  import harvard_pkg::*;
#(
  parameter int                  PC_WIDTH   = 8,
  parameter int                  DATA_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 clkInput,
  input  logic                 resetNInput,
  input  logic                 startInput,
`ifdef SINGLE_STEP_EN
  input  logic                 stepInput,
`endif
  output logic                 busyOutput,
  output logic                 haltedOutput,
  control_sequencer_if.master  bus
);

  seqStateT               state;
  logic [PC_WIDTH-1:0]    pc;
  logic [DATA_WIDTH-1:0]  acc;
  logic                   condFlag;
  logic [INSTR_WIDTH-1:0] ir;
  logic                   writeStrobe;
  logic [4:0]             opcode;

  assign opcode = ir[OPC_MSB:OPC_LSB];

  sequencer_fsm u_fsm (
    .clkInput     (clkInput),
    .resetNInput  (resetNInput),
    .startInput   (startInput),
`ifdef SINGLE_STEP_EN
    .stepInput    (stepInput),
`endif
    .endFlagInput (bus.EndFlagInput),
    .state        (state),
    .busyOutput   (busyOutput),
    .haltedOutput (haltedOutput)
  );

  always_ff @(posedge clkInput) begin
    if (!resetNInput) begin
      pc          <= RESET_PC;
      acc         <= '0;
      condFlag    <= 1'b0;
      ir          <= '0;
      writeStrobe <= 1'b0;
    end else begin
      writeStrobe <= 1'b0;
      case (state)
        IDLE, HALT: if (startInput) begin
          pc       <= RESET_PC;
          acc      <= '0;
          condFlag <= 1'b0;
        end
        DECODE:  ir          <= bus.ProgramDataInput;
        // Raised one cycle early so the strobe occupies exactly the WRITEBACK cycle.
        EXECUTE: writeStrobe <= isStore(opcode);
        WRITEBACK: begin
          condFlag <= bus.ConditionFlagWriteInput;
          if (!isStore(opcode) && !isJump(opcode))
            acc <= bus.AccumulatorWriteInput;
          // PC wraps naturally at the top of the ROM.
          pc <= isJump(opcode) ? bus.ProgramCounterInput : pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ProgramAddressOutput = pc;
  assign bus.OperandOutput        = opcode;
  assign bus.OutputSelectorOutput = ir[SEL_MSB:SEL_LSB];
  assign bus.DataAddressOutput    = ir[ADDR_MSB:ADDR_LSB];
  assign bus.AccumulatorOutput    = acc;
  assign bus.ConditionFlagOutput  = condFlag;
  // Reset asserted during WRITEBACK must suppress the write sampled at that edge.
  assign bus.DataWriteEnableOutput = writeStrobe & resetNInput;

endmodule
